addr_decoding: RTL and testbench
================================

Name: addr_decoding

Overview:
- Address decoder for the MIPS CPU data-memory map.
- Compares the 32-bit bus address against a fixed window [BASE, BASE+SIZE-1] and drives a registered chip-select for the data memory.
- Also provides the window-relative offset, so the memory can index its array directly.
- Sits between the CPU address bus (ALU result / memory-address register) and the data-memory chip-select input.

Parameters:
- ADDR_W, 32, bus address width in bits.
- BASE, 32'h0000_1730, first byte address inside the window (inclusive).
- SIZE, 32'h0000_0400, window length in bytes; last address is BASE+SIZE-1 = 32'h0000_1B2F.
- OFFSET_W, 10, width of the offset output; must satisfy 2^OFFSET_W >= SIZE.

Ports:
- Clk, input, 1, system clock; rising-edge active.
- Reset_n, input, 1, asynchronous active-low reset.
- adress, input, ADDR_W, bus address to decode (codebase spelling retained).
- cs, output, 1, chip select; 1 when the sampled address lies inside the window.
- offset, output, OFFSET_W, sampled address minus BASE; valid only when cs=1.

Behaviour:
- Hit condition is unsigned: hit = (adress >= BASE) && (adress <= BASE+SIZE-1).
  - Compute the upper bound at ADDR_W+1 bits so that BASE+SIZE never wraps.
  - Both bounds are inclusive.
- cs and offset are registered, with one-cycle latency.
  - On each rising Clk edge: cs <= hit; offset <= hit ? (adress-BASE)[OFFSET_W-1:0] : 0.
- Reset: while Reset_n=0, cs=0 and offset=0, asynchronously.
  - Asserting reset mid-operation clears both outputs immediately, without waiting for a clock edge.
  - Deassertion is synchronised by the first following rising edge; decoding resumes on that edge.
- No other state. adress changes between edges have no effect until the next edge.
- Boundaries:
  - BASE-1 gives cs=0.
  - BASE gives cs=1, offset=0.
  - BASE+SIZE-1 gives cs=1, offset=SIZE-1.
  - BASE+SIZE gives cs=0.
  - 32'hFFFF_FFFF and 32'h0 give cs=0; no wrap-around aliasing.
- Misaligned addresses decode by byte address, with no alignment check.
- X/Z on adress is not filtered; behaviour under X is undefined.
- Elaboration-time checks (generate-time assertion):
  - SIZE > 0.
  - BASE+SIZE-1 fits in ADDR_W bits.
  - 2^OFFSET_W >= SIZE.

Decomposition:
- Shared package (mips_mem_map_pkg) holds:
  - address-map constants DMEM_BASE=32'h1730 and DMEM_SIZE=32'h400;
  - the ADDR_W default;
  - a typedef addr_t (logic [31:0]).
- Natural sub-module: range_compare, a purely combinational unsigned lo<=x<=hi comparator that outputs hit and x-lo.
  - Reusable for future peripheral windows.
  - addr_decoding instantiates it and adds the output register stage plus reset.

Test Plan:
- Reset: hold Reset_n=0 with adress=32'h1800 for 3 edges -> cs=0, offset=0. Release reset -> cs=1 after the first rising edge.
- Lower boundary: adress=32'h172F -> cs=0 one edge later. Then 32'h1730 -> cs=1, offset=0 one edge later.
- Interior: adress=32'h1800 -> cs=1, offset=10'h0D0.
- Upper boundary: adress=32'h1B2F -> cs=1, offset=10'h3FF. Then 32'h1B30 -> cs=0, offset=0.
- Extremes: adress=32'h0000_0000, 32'hFFFF_FFFF, and 32'h0001_1730 (aliases under a 16-bit-only compare) -> cs=0 each.
- Async reset mid-stream: with cs=1 at adress=32'h1900, pull Reset_n low between edges -> cs falls to 0 immediately, before the next rising edge.

Source files
------------

// File: rtl/mips_mem_map_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_map_pkg
// Address-map constants and common types for the MIPS CPU memory system.
//   ADDR_W    : default bus address width in bits
//   DMEM_BASE : first byte address of the data-memory window
//   DMEM_SIZE : data-memory window length in bytes
//   addr_t    : bus address type
// -----------------------------------------------------------------------------
package mips_mem_map_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t DMEM_BASE = 32'h0000_1730;
  localparam addr_t DMEM_SIZE = 32'h0000_0400;

endpackage : mips_mem_map_pkg

// File: rtl/addr_decoding_if.sv
// -----------------------------------------------------------------------------
// addr_decoding_if
// Connects the CPU address bus to the data-memory select and offset signals.
//   adress : bus address to decode (the codebase's spelling is kept)
//   cs     : registered chip select for the data memory
//   offset : registered window-relative byte offset, valid when cs=1
// Modports: master (the CPU side, drives adress), slave (the decoder).
// -----------------------------------------------------------------------------
interface addr_decoding_if
  import mips_mem_map_pkg::*;
#(
  parameter int unsigned ADDR_W   = mips_mem_map_pkg::ADDR_W,
  parameter int unsigned OFFSET_W = 10
);

  logic [ADDR_W-1:0]   adress;
  logic                cs;
  logic [OFFSET_W-1:0] offset;

  modport master (output adress, input  cs, input  offset);
  modport slave  (input  adress, output cs, output offset);

endinterface : addr_decoding_if

// File: rtl/addr_decoding_range_compare.sv
// -----------------------------------------------------------------------------
// range_compare
// Purely combinational unsigned window comparator: hit = lo <= x <= hi.
// It can be reused for other peripheral windows.
//   x    : value to test (W bits)
//   lo   : inclusive lower bound (W bits)
//   hi   : inclusive upper bound (W+1 bits, so lo+size-1 never wraps)
//   hit  : 1 when x lies inside [lo, hi]
//   diff : (x - lo) truncated to OW bits
// -----------------------------------------------------------------------------
module range_compare #(
  parameter int unsigned W  = 32,
  parameter int unsigned OW = 10
) (
  input  logic [W-1:0]  x,
  input  logic [W-1:0]  lo,
  input  logic [W:0]    hi,
  output logic          hit,
  output logic [OW-1:0] diff
);

  // The comparison is done at W+1 bits. With a W-bit compare, a window that
  // ends at the very top of the address space would wrap.
  assign hit  = ({1'b0, x} >= {1'b0, lo}) && ({1'b0, x} <= hi);
  assign diff = OW'(x - lo);

endmodule : range_compare

// File: rtl/addr_decoding.sv
// -----------------------------------------------------------------------------
// addr_decoding
// Data-memory address decoder for the MIPS CPU. It compares the bus address
// against [BASE, BASE+SIZE-1]. It registers the chip select and the
// window-relative offset, with one cycle of latency.
//   Clk     : system clock, rising edge active
//   Reset_n : asynchronous active-low reset; clears cs and offset
//   bus     : addr_decoding_if slave (adress in; cs, offset out)
// -----------------------------------------------------------------------------
module addr_decoding
  import mips_mem_map_pkg::*;
#(
  parameter int unsigned         ADDR_W   = mips_mem_map_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]   BASE     = DMEM_BASE,
  parameter logic [ADDR_W-1:0]   SIZE     = DMEM_SIZE,
  parameter int unsigned         OFFSET_W = 10
) (
  input  logic           Clk,
  input  logic           Reset_n,
  addr_decoding_if.slave bus
);

  // The last address in the window is held one bit wider than the bus, so
  // the elaboration checks below can detect a window that overflows.
  localparam logic [ADDR_W:0] HI = {1'b0, BASE} + {1'b0, SIZE} - 1'b1;

  if (SIZE == '0) begin : g_bad_size
    $error("addr_decoding: SIZE must be non-zero");
  end
  if (HI[ADDR_W]) begin : g_bad_hi
    $error("addr_decoding: BASE+SIZE-1 does not fit in ADDR_W bits");
  end
  if ((64'd1 << OFFSET_W) < 64'(SIZE)) begin : g_bad_offset_w
    $error("addr_decoding: OFFSET_W too narrow for SIZE");
  end

  logic                hit;
  logic [OFFSET_W-1:0] diff;

  range_compare #(
    .W  (ADDR_W),
    .OW (OFFSET_W)
  ) u_range_compare (
    .x    (bus.adress),
    .lo   (BASE),
    .hi   (HI),
    .hit  (hit),
    .diff (diff)
  );

  // NOTE: Reset is asynchronous, so it is in the sensitivity list. Registered
  // state uses non-blocking assignments, so every flop samples values from
  // before the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.cs     <= 1'b0;
      bus.offset <= '0;
    end else begin
      bus.cs     <= hit;
      bus.offset <= hit ? diff : '0;
    end
  end

endmodule : addr_decoding

// File: tb/tb_addr_decoding.sv
// -----------------------------------------------------------------------------
// tb_addr_decoding
// Self-checking bench for addr_decoding. Each driven address pushes its
// expected {cs, offset} onto a queue. The entry is popped and compared
// after the next rising edge.
// -----------------------------------------------------------------------------
module tb_addr_decoding;

  logic Clk;
  logic Reset_n;

  addr_decoding_if #(.ADDR_W(32), .OFFSET_W(10)) bus ();

  addr_decoding dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic        cs;
    logic [9:0]  off;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        cs;
    logic [9:0]  off;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference for the data-memory window.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.cs   = (a >= 32'h0000_1730) && (a <= 32'h0000_1B2F);
    e.off  = e.cs ? 10'(a - 32'h0000_1730) : 10'h0;
    return e;
  endfunction

  // Drive on the falling edge and queue the expected result.
  task automatic drive(input logic [31:0] a, input logic exp_cs, input logic [9:0] exp_off);
    exp_t e;
    @(negedge Clk);
    bus.adress = a;
    e.addr = a;
    e.cs   = exp_cs;
    e.off  = exp_off;
    sb.push_back(e);
  endtask

  // Sample just after the rising edge and compare against the queue head.
  task automatic sample(input string name);
    exp_t e;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got cs=%0b", name, bus.cs);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s cs @%h", name, e.addr), 32'(bus.cs), 32'(e.cs));
      check($sformatf("%s offset @%h", name, e.addr), 32'(bus.offset), 32'(e.off));
    end
  endtask

  // Watchdog: force the summary line if the run stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"below_base", 32'h0000_172F, 1'b0, 10'h000};
    vecs[1] = '{"base",       32'h0000_1730, 1'b1, 10'h000};
    vecs[2] = '{"interior",   32'h0000_1800, 1'b1, 10'h0D0};
    vecs[3] = '{"last",       32'h0000_1B2F, 1'b1, 10'h3FF};
    vecs[4] = '{"past_end",   32'h0000_1B30, 1'b0, 10'h000};
    vecs[5] = '{"zero",       32'h0000_0000, 1'b0, 10'h000};
    vecs[6] = '{"all_ones",   32'hFFFF_FFFF, 1'b0, 10'h000};
    vecs[7] = '{"alias16",    32'h0001_1730, 1'b0, 10'h000};
    vecs[8] = '{"misaligned", 32'h0000_1731, 1'b1, 10'h001};
    vecs[9] = '{"interior2",  32'h0000_1A00, 1'b1, 10'h2D0};

    Reset_n    = 1'b0;
    bus.adress = 32'h0000_1800;

    // Hold reset across three edges with an in-window address.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk);
      #1;
      check("reset cs", 32'(bus.cs), 32'h0);
      check("reset offset", 32'(bus.offset), 32'h0);
    end

    // Release reset. Decoding resumes on the first rising edge after release.
    @(negedge Clk);
    Reset_n = 1'b1;
    sb.push_back(model(32'h0000_1800));
    sample("post_reset");

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].cs, vecs[i].off);
      sample(vecs[i].name);
    end

    // Random addresses near the window, checked against the model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      exp_t        e;
      a = 32'($urandom_range(32'h1C40, 32'h1600));
      e = model(a);
      drive(a, e.cs, e.off);
      sample("random");
    end

    // A change of address between edges must not affect the outputs.
    drive(32'h0000_1900, 1'b1, 10'h1D0);
    sample("hold_setup");
    @(negedge Clk);
    bus.adress = 32'h0000_0000;
    #2;
    check("between_edges cs", 32'(bus.cs), 32'h1);
    check("between_edges offset", 32'(bus.offset), 32'h1D0);

    // Asynchronous reset mid-stream clears the outputs before the next edge.
    drive(32'h0000_1900, 1'b1, 10'h1D0);
    sample("async_setup");
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset cs", 32'(bus.cs), 32'h0);
    check("async_reset offset", 32'(bus.offset), 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    sb.push_back(model(32'h0000_1900));
    sample("async_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_addr_decoding
